// File: rtl/perf_pkg.sv
// Shared types and constants for the performance counter bank.
// Channel indices name the CPU event strobes wired into the bank.
package perf_pkg;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    FROZEN = 1'b1
  } perf_state_e;

  localparam int DEF_CNT_W  = 32;
  localparam int DEF_NUM_CH = 6;

  localparam int CH_ICREQ  = 0;
  localparam int CH_ICHIT  = 1;
  localparam int CH_DCREQ  = 2;
  localparam int CH_DCHIT  = 3;
  localparam int CH_RETIRE = 4;
  localparam int CH_MEMWR  = 5;

endpackage

// File: rtl/perf_counter_bank_if.sv
// Read port of the counter bank: request/select in, registered valid/data out.
interface perf_counter_bank_if #(
  parameter int SEL_W = 5,
  parameter int CNT_W = 32
);
  logic             rd_req;
  logic [SEL_W-1:0] rd_sel;
  logic             rd_valid;
  logic [CNT_W-1:0] rd_data;

  modport master (output rd_req, output rd_sel, input rd_valid, input rd_data);
  modport slave  (input rd_req, input rd_sel, output rd_valid, output rd_data);
endinterface

// File: rtl/perf_counter.sv
// One event counter with synchronous clear, saturate-or-wrap overflow
// policy and a sticky overflow flag.
module perf_counter #(
  parameter int CNT_W    = 32,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  // Next count: clear wins, then increment with overflow handling.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc_i) begin
      if (cnt_q == {CNT_W{1'b1}}) begin
        ovf_d = 1'b1;
        cnt_d = SATURATE ? cnt_q : '0;
      end else begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count and overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH event counters plus a cycle counter, frozen on CPU halt,
// read through a one-cycle-latency pipelined request/valid port.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int CNT_W    = DEF_CNT_W,
  parameter bit SATURATE = 1'b1,
  parameter int SEL_W    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [NUM_CH-1:0] events,
  input  logic              hlt,
  perf_counter_bank_if.slave rd_bus,
  output logic [NUM_CH:0]   ovf,
  output logic              frozen
);

  perf_state_e state_q, state_d;
  logic                        count_en_s;
  logic [NUM_CH:0]             inc_s;
  logic [NUM_CH:0][CNT_W-1:0]  cnt_s;
  logic [CNT_W-1:0]            mux_s;
  logic                        rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0]            rd_data_q, rd_data_d;

  // Freeze on halt only while enabled; only clear thaws the bank.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (clr)             state_d = RUN;
        else if (en && hlt)  state_d = FROZEN;
        else                 state_d = RUN;
      end
      FROZEN: begin
        if (clr) state_d = RUN;
        else     state_d = FROZEN;
      end
      default: state_d = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  assign count_en_s = en && !clr && (state_q == RUN);
  assign inc_s      = {count_en_s, events & {NUM_CH{count_en_s}}};

  for (genvar g = 0; g <= NUM_CH; g++) begin : g_cnt
    perf_counter #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (clr),
      .inc_i (inc_s[g]),
      .cnt_o (cnt_s[g]),
      .ovf_o (ovf[g])
    );
  end

  // Read mux; selects beyond the cycle counter return zero.
  always_comb begin
    mux_s = '0;
    for (int i = 0; i <= NUM_CH; i++) begin
      if (rd_bus.rd_sel == SEL_W'(i)) mux_s = cnt_s[i];
    end
  end

  // Capture the pre-update value on request; hold data otherwise.
  always_comb begin
    rd_valid_d = rd_bus.rd_req;
    if (rd_bus.rd_req) rd_data_d = mux_s;
    else               rd_data_d = rd_data_q;
  end

  // Read response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_bus.rd_valid = rd_valid_q;
  assign rd_bus.rd_data  = rd_data_q;
  assign frozen          = (state_q == FROZEN);

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: a default 32-bit instance plus two
// 4-bit instances (saturating and wrapping) for overflow behaviour.
module tb_perf_counter_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, clr, hlt;
  logic [5:0]  events;
  logic [6:0]  ovf;
  logic        frozen;

  logic        en4, clr4;
  logic [5:0]  ev4;
  logic [6:0]  ovf_s, ovf_w;
  logic        frozen_s, frozen_w;

  int pass_cnt = 0;
  int total_cnt = 0;

  perf_counter_bank_if #(.SEL_W(5), .CNT_W(32)) bus ();
  perf_counter_bank_if #(.SEL_W(5), .CNT_W(4))  bus_s ();
  perf_counter_bank_if #(.SEL_W(5), .CNT_W(4))  bus_w ();

  perf_counter_bank #(.NUM_CH(6), .CNT_W(32), .SATURATE(1'b1), .SEL_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .events(events), .hlt(hlt),
    .rd_bus(bus), .ovf(ovf), .frozen(frozen)
  );

  perf_counter_bank #(.NUM_CH(6), .CNT_W(4), .SATURATE(1'b1), .SEL_W(5)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en4), .clr(clr4), .events(ev4), .hlt(1'b0),
    .rd_bus(bus_s), .ovf(ovf_s), .frozen(frozen_s)
  );

  perf_counter_bank #(.NUM_CH(6), .CNT_W(4), .SATURATE(1'b0), .SEL_W(5)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .en(en4), .clr(clr4), .events(ev4), .hlt(1'b0),
    .rd_bus(bus_w), .ovf(ovf_w), .frozen(frozen_w)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [4:0] s, output logic v, output logic [31:0] d);
    bus.rd_req = 1'b1;
    bus.rd_sel = s;
    step();
    v = bus.rd_valid;
    d = bus.rd_data;
    bus.rd_req = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; hlt = 1'b0; events = 6'd0;
    en4 = 1'b0; clr4 = 1'b0; ev4 = 6'd0;
    bus.rd_req = 1'b0; bus.rd_sel = 5'd0;
    bus_s.rd_req = 1'b0; bus_s.rd_sel = 5'd0;
    bus_w.rd_req = 1'b0; bus_w.rd_sel = 5'd0;
    #23;
    total_cnt++;
    if (frozen !== 1'b0 || ovf !== 7'd0 || bus.rd_valid !== 1'b0 || bus.rd_data !== 32'd0)
      $display("FAIL reset: frozen=%b ovf=%b valid=%b data=%0d, need 0/0/0/0",
               frozen, ovf, bus.rd_valid, bus.rd_data);
    else pass_cnt++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_count();
    logic v; logic [31:0] d;
    en = 1'b1; events = 6'b000011;
    for (int i = 0; i < 10; i++) step();
    events = 6'd0;
    bus.rd_req = 1'b1; bus.rd_sel = 5'd0;
    total_cnt++;
    if (bus.rd_valid !== 1'b0) $display("FAIL count_valid_early: got %b need 0", bus.rd_valid);
    else pass_cnt++;
    do_read(5'd0, v, d);
    total_cnt++;
    if (v !== 1'b1 || d !== 32'd10) $display("FAIL count_ch0: valid=%b data=%0d need 1/10", v, d);
    else pass_cnt++;
    do_read(5'd1, v, d);
    total_cnt++;
    if (v !== 1'b1 || d !== 32'd10) $display("FAIL count_ch1: valid=%b data=%0d need 1/10", v, d);
    else pass_cnt++;
    do_read(5'd6, v, d);
    total_cnt++;
    if (v !== 1'b1 || d !== 32'd12) $display("FAIL count_cycle: valid=%b data=%0d need 1/12", v, d);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 32'd12)
      $display("FAIL count_idle: valid=%b data=%0d need 0/12", bus.rd_valid, bus.rd_data);
    else pass_cnt++;
  endtask

  task automatic test_halt_freeze();
    logic v; logic [31:0] d;
    pulse_clr();
    hlt = 1'b1; events = 6'b000100;
    step();
    total_cnt++;
    if (frozen !== 1'b1) $display("FAIL halt_frozen: got %b need 1", frozen);
    else pass_cnt++;
    hlt = 1'b0; events = 6'h3F;
    for (int i = 0; i < 5; i++) step();
    events = 6'd0;
    do_read(5'd2, v, d);
    total_cnt++;
    if (d !== 32'd1) $display("FAIL halt_ch2: got %0d need 1", d);
    else pass_cnt++;
    do_read(5'd0, v, d);
    total_cnt++;
    if (d !== 32'd0) $display("FAIL halt_ch0: got %0d need 0", d);
    else pass_cnt++;
    do_read(5'd6, v, d);
    total_cnt++;
    if (v !== 1'b1 || d !== 32'd1 || frozen !== 1'b1)
      $display("FAIL halt_cycle: valid=%b data=%0d frozen=%b need 1/1/1", v, d, frozen);
    else pass_cnt++;
    pulse_clr();
    total_cnt++;
    if (frozen !== 1'b0 || ovf !== 7'd0) $display("FAIL halt_clr: frozen=%b ovf=%b need 0/0", frozen, ovf);
    else pass_cnt++;
    do_read(5'd2, v, d);
    total_cnt++;
    if (d !== 32'd0) $display("FAIL halt_clr_ch2: got %0d need 0", d);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    en4 = 1'b1; ev4 = 6'b000001;
    for (int i = 0; i < 17; i++) step();
    en4 = 1'b0; ev4 = 6'd0;
    bus_s.rd_req = 1'b1; bus_s.rd_sel = 5'd0;
    bus_w.rd_req = 1'b1; bus_w.rd_sel = 5'd0;
    step();
    bus_s.rd_req = 1'b0; bus_w.rd_req = 1'b0;
    total_cnt++;
    if (bus_s.rd_data !== 4'd15 || ovf_s !== 7'b1000001)
      $display("FAIL ovf_sat: data=%0d ovf=%b need 15/1000001", bus_s.rd_data, ovf_s);
    else pass_cnt++;
    total_cnt++;
    if (bus_w.rd_data !== 4'd1 || ovf_w !== 7'b1000001)
      $display("FAIL ovf_wrap: data=%0d ovf=%b need 1/1000001", bus_w.rd_data, ovf_w);
    else pass_cnt++;
    clr4 = 1'b1;
    step();
    clr4 = 1'b0;
    bus_s.rd_req = 1'b1; bus_w.rd_req = 1'b1;
    step();
    bus_s.rd_req = 1'b0; bus_w.rd_req = 1'b0;
    total_cnt++;
    if (ovf_s !== 7'd0 || ovf_w !== 7'd0 || bus_s.rd_data !== 4'd0 || bus_w.rd_data !== 4'd0
        || frozen_s !== 1'b0 || frozen_w !== 1'b0)
      $display("FAIL ovf_clr: ovf_s=%b ovf_w=%b ds=%0d dw=%0d need all 0",
               ovf_s, ovf_w, bus_s.rd_data, bus_w.rd_data);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic v; logic [31:0] d;
    logic [31:0] exp_d;
    pulse_clr();
    events = 6'b001000;
    for (int i = 0; i < 7; i++) step();
    do_read(5'd3, v, d);
    total_cnt++;
    if (d !== 32'd7) $display("FAIL rd_during_inc: got %0d need 7", d);
    else pass_cnt++;
    events = 6'd0;
    do_read(5'd3, v, d);
    total_cnt++;
    if (d !== 32'd8) $display("FAIL rd_after_inc: got %0d need 8", d);
    else pass_cnt++;
    bus.rd_req = 1'b1;
    for (int s = 0; s < 8; s++) begin
      bus.rd_sel = 5'(s);
      step();
      exp_d = (s == 3) ? 32'd8 : (s == 6) ? 32'd15 : 32'd0;
      total_cnt++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_d)
        $display("FAIL b2b_sel%0d: valid=%b data=%0d need 1/%0d", s, bus.rd_valid, bus.rd_data, exp_d);
      else pass_cnt++;
    end
    bus.rd_req = 1'b0;
    step();
    total_cnt++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 32'd0)
      $display("FAIL b2b_end: valid=%b data=%0d need 0/0", bus.rd_valid, bus.rd_data);
    else pass_cnt++;
  endtask

  task automatic test_clr_priority();
    logic v; logic [31:0] d;
    pulse_clr();
    events = 6'b000001;
    for (int i = 0; i < 5; i++) step();
    clr = 1'b1; hlt = 1'b1; bus.rd_req = 1'b1; bus.rd_sel = 5'd0;
    step();
    clr = 1'b0; hlt = 1'b0; events = 6'd0; bus.rd_req = 1'b0;
    total_cnt++;
    if (bus.rd_data !== 32'd5 || frozen !== 1'b0)
      $display("FAIL clr_cycle_read: data=%0d frozen=%b need 5/0", bus.rd_data, frozen);
    else pass_cnt++;
    do_read(5'd0, v, d);
    total_cnt++;
    if (d !== 32'd0) $display("FAIL clr_prio_ch0: got %0d need 0", d);
    else pass_cnt++;
    do_read(5'd6, v, d);
    total_cnt++;
    if (d !== 32'd1) $display("FAIL clr_prio_cycle: got %0d need 1", d);
    else pass_cnt++;
    en = 1'b0; hlt = 1'b1; events = 6'h3F;
    for (int i = 0; i < 3; i++) step();
    total_cnt++;
    if (frozen !== 1'b0) $display("FAIL en0_no_freeze: got %b need 0", frozen);
    else pass_cnt++;
    do_read(5'd0, v, d);
    total_cnt++;
    if (d !== 32'd0) $display("FAIL en0_ch0: got %0d need 0", d);
    else pass_cnt++;
    do_read(5'd6, v, d);
    total_cnt++;
    if (v !== 1'b1 || d !== 32'd2) $display("FAIL en0_cycle: valid=%b data=%0d need 1/2", v, d);
    else pass_cnt++;
    hlt = 1'b0; events = 6'd0; en = 1'b1;
  endtask

  task automatic test_async_reset();
    logic v; logic [31:0] d;
    pulse_clr();
    events = 6'b000001;
    for (int i = 0; i < 8; i++) step();
    hlt = 1'b1;
    step();
    hlt = 1'b0; events = 6'd0;
    do_read(5'd0, v, d);
    total_cnt++;
    if (d !== 32'd9 || frozen !== 1'b1) $display("FAIL pre_rst: data=%0d frozen=%b need 9/1", d, frozen);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (frozen !== 1'b0 || bus.rd_valid !== 1'b0 || bus.rd_data !== 32'd0 || ovf !== 7'd0)
      $display("FAIL async_rst: frozen=%b valid=%b data=%0d ovf=%b need all 0",
               frozen, bus.rd_valid, bus.rd_data, ovf);
    else pass_cnt++;
    step();
    rst_n = 1'b1;
    events = 6'b000001;
    for (int i = 0; i < 3; i++) step();
    events = 6'd0;
    do_read(5'd0, v, d);
    total_cnt++;
    if (d !== 32'd3 || frozen !== 1'b0) $display("FAIL post_rst: data=%0d frozen=%b need 3/0", d, frozen);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_count();
    test_halt_freeze();
    test_overflow();
    test_back_to_back();
    test_clr_priority();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
